// File: rtl/wb_regfile_stage.sv
// ---------------------------------------------------------------------------
// wb_regfile_stage
//
// Writeback stage of the 5-stage pipeline. It sits directly after the memory
// stage and takes the MEM/WB pipeline register outputs. It picks the
// writeback value from a one-hot source select and commits that value to an
// 8-entry register file. It also provides:
//   - two combinational decode read ports with write-through bypass,
//   - a same-cycle forwarding tap for the execute stage,
//   - retire and illegal-select counters,
//   - a flat view of every register for debug.
//
// Ports
//   clk, resetn                      clock; asynchronous active-low reset
//   mem_wb_regwrite                  write enable for this writeback
//   mem_wb_reg_wb_enc                destination register index
//   mem_wb_reg_arithmetic_result     ALU result
//   mem_wb_reg_memory_wb_data        load data wire from the byte BRAMs;
//                                    the addressed byte is in the top byte
//   mem_wb_reg_operand_val2          pass-through operand (move/immediate)
//   mem_wb_reg_data_select_hotcode   one-hot source select
//                                    (ALU / word / byte / val2)
//   wb_instruct                      instruction in WB; all-zero = bubble
//   rd_addr_a/b, rd_data_a/b         decode read ports
//   wb_fwd_valid/enc/data            forwarding tap (combinational)
//   retired_count                    non-bubble instructions retired (wraps)
//   illegal_sel_count                saturating count of illegal selects
//   illegal_sel_sticky               set by the first illegal select
//   regs_flat                        register k at bits [32k+31:32k]
//
// Handshake: there is no flow control in this block. A writeback is
// presented for exactly one cycle. It is committed on the next rising clk
// edge if the write is legal. Nothing is ever stalled or acknowledged.
// ---------------------------------------------------------------------------
module wb_regfile_stage #(
    parameter int DATA_W    = 32,
    parameter int R0_ZERO   = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mem_wb_regwrite,
    input  logic [2:0]             mem_wb_reg_wb_enc,
    input  logic [DATA_W-1:0]      mem_wb_reg_arithmetic_result,
    input  logic [DATA_W-1:0]      mem_wb_reg_memory_wb_data,
    input  logic [DATA_W-1:0]      mem_wb_reg_operand_val2,
    input  logic [3:0]             mem_wb_reg_data_select_hotcode,
    input  logic [31:0]            wb_instruct,
    input  logic [2:0]             rd_addr_a,
    input  logic [2:0]             rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    output logic                   wb_fwd_valid,
    output logic [2:0]             wb_fwd_enc,
    output logic [DATA_W-1:0]      wb_fwd_data,
    output logic [31:0]            retired_count,
    output logic [ERR_CNT_W-1:0]   illegal_sel_count,
    output logic                   illegal_sel_sticky,
    output logic [8*DATA_W-1:0]    regs_flat
);

    localparam int NREGS = 8;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]    regs_q [NREGS];
    logic [DATA_W-1:0]    regs_d [NREGS];
    logic [31:0]          retired_q, retired_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 sticky_q, sticky_d;

    // -----------------------------------------------------------------------
    // Source select
    // -----------------------------------------------------------------------
    logic [3:0]        hot;
    logic              sel_legal;
    logic              r0_blocked;
    logic              we_eff;
    logic              illegal_evt;
    logic [DATA_W-1:0] wb_data;

    assign hot = mem_wb_reg_data_select_hotcode;

    // A select is legal only when exactly one bit is set. Clearing the lowest
    // set bit must leave zero, and the select itself must be nonzero.
    assign sel_legal = (hot != 4'b0000) && ((hot & (hot - 4'b0001)) == 4'b0000);

    always_comb begin
        wb_data = '0;
        unique case (hot)
            4'b0001: wb_data = mem_wb_reg_arithmetic_result;
            4'b0010: wb_data = mem_wb_reg_memory_wb_data;
            4'b0100: wb_data = {{(DATA_W-8){1'b0}},
                                mem_wb_reg_memory_wb_data[DATA_W-1 -: 8]};
            4'b1000: wb_data = mem_wb_reg_operand_val2;
            default: wb_data = '0;
        endcase
    end

    // With R0_ZERO set, register 0 is hardwired to zero. A write to it is
    // dropped before it can reach the file or the forwarding tap.
    assign r0_blocked  = (R0_ZERO != 0) && (mem_wb_reg_wb_enc == 3'd0);
    assign we_eff      = mem_wb_regwrite && sel_legal && !r0_blocked;
    assign illegal_evt = mem_wb_regwrite && !sel_legal;

    // -----------------------------------------------------------------------
    // Forwarding tap: same-cycle view of the write about to commit
    // -----------------------------------------------------------------------
    assign wb_fwd_valid = we_eff;
    assign wb_fwd_enc   = mem_wb_reg_wb_enc;
    assign wb_fwd_data  = wb_data;

    // -----------------------------------------------------------------------
    // Register file next state
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            regs_d[k] = regs_q[k];
        end
        if (we_eff) begin
            regs_d[mem_wb_reg_wb_enc] = wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Counters
    // -----------------------------------------------------------------------
    always_comb begin
        retired_d = retired_q;
        err_cnt_d = err_cnt_q;
        sticky_d  = sticky_q;
        // Every non-bubble instruction retires, whether or not it writes.
        if (wb_instruct != 32'h0) begin
            retired_d = retired_q + 32'd1;
        end
        if (illegal_evt) begin
            sticky_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            retired_q <= '0;
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            retired_q <= retired_d;
            err_cnt_q <= err_cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports with write-through bypass
    // -----------------------------------------------------------------------
    // A decode read in the same cycle as a writeback to the same index sees
    // the new value. This keeps the file free of a write-then-read hazard.
    function automatic logic [DATA_W-1:0] read_port(input logic [2:0] addr);
        logic [DATA_W-1:0] val;
        if ((R0_ZERO != 0) && (addr == 3'd0)) begin
            val = '0;
        end else if (we_eff && (addr == mem_wb_reg_wb_enc)) begin
            val = wb_data;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign retired_count      = retired_q;
    assign illegal_sel_count  = err_cnt_q;
    assign illegal_sel_sticky = sticky_q;

    // Debug view shows registered contents only, with no bypass.
    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Two instances run from the same inputs. Instance 0 has register 0 as an
// ordinary register. Instance 1 has register 0 hardwired to zero.
module tb_wb_regfile_stage;

  logic        clk;
  logic        resetn;
  logic        regwrite;
  logic [2:0]  enc;
  logic [31:0] alu;
  logic [31:0] mem;
  logic [31:0] val2;
  logic [3:0]  hot;
  logic [31:0] instr;
  logic [2:0]  ra;
  logic [2:0]  rb;

  logic [31:0]  rd_a [2];
  logic [31:0]  rd_b [2];
  logic         fwd_v [2];
  logic [2:0]   fwd_e [2];
  logic [31:0]  fwd_d [2];
  logic [31:0]  ret_c [2];
  logic [7:0]   err_c [2];
  logic         stk [2];
  logic [255:0] flat [2];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_regfile_stage #(
      .DATA_W(32), .R0_ZERO(g), .ERR_CNT_W(8)
    ) u_dut (
      .clk                            (clk),
      .resetn                         (resetn),
      .mem_wb_regwrite                (regwrite),
      .mem_wb_reg_wb_enc              (enc),
      .mem_wb_reg_arithmetic_result   (alu),
      .mem_wb_reg_memory_wb_data      (mem),
      .mem_wb_reg_operand_val2        (val2),
      .mem_wb_reg_data_select_hotcode (hot),
      .wb_instruct                    (instr),
      .rd_addr_a                      (ra),
      .rd_addr_b                      (rb),
      .rd_data_a                      (rd_a[g]),
      .rd_data_b                      (rd_b[g]),
      .wb_fwd_valid                   (fwd_v[g]),
      .wb_fwd_enc                     (fwd_e[g]),
      .wb_fwd_data                    (fwd_d[g]),
      .retired_count                  (ret_c[g]),
      .illegal_sel_count              (err_c[g]),
      .illegal_sel_sticky             (stk[g]),
      .regs_flat                      (flat[g])
    );
  end

  // scoreboard / reference model
  int checks;
  int failures;
  logic [31:0] m_regs [2][8];
  int unsigned m_retired;
  int          m_err;
  bit          m_sticky;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal();
    return hot inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  function automatic logic [31:0] m_value();
    case (hot)
      4'b0001: return alu;
      4'b0010: return mem;
      4'b0100: return mem >> 24;
      4'b1000: return val2;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_we(input int d);
    return regwrite && m_legal() && !(d == 1 && enc == 3'd0);
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [2:0] a);
    if (d == 1 && a == 3'd0) return 32'h0;
    if (m_we(d) && a == enc) return m_value();
    return m_regs[d][a];
  endfunction

  function automatic logic [255:0] m_flat(input int d);
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = m_regs[d][k];
    return f;
  endfunction

  task automatic m_clear();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) m_regs[d][k] = 32'h0;
    m_retired = 0;
    m_err     = 0;
    m_sticky  = 0;
  endtask

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.flat%0d", tag, d), flat[d], m_flat(d));
      check($sformatf("%s.ret%0d", tag, d), ret_c[d], m_retired);
      check($sformatf("%s.err%0d", tag, d), err_c[d], m_err);
      check($sformatf("%s.stk%0d", tag, d), stk[d], m_sticky);
    end
  endtask

  task automatic check_comb(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.fv%0d", tag, d), fwd_v[d], m_we(d));
      check($sformatf("%s.fe%0d", tag, d), fwd_e[d], enc);
      if (m_legal()) check($sformatf("%s.fd%0d", tag, d), fwd_d[d], m_value());
      check($sformatf("%s.rda%0d", tag, d), rd_a[d], m_read(d, ra));
      check($sformatf("%s.rdb%0d", tag, d), rd_b[d], m_read(d, rb));
    end
  endtask

  // Clock edge: update the model from the current inputs, then check state.
  task automatic commit(input string tag);
    logic [31:0] v;
    bit w0, w1;
    @(posedge clk);
    v  = m_value();
    w0 = m_we(0);
    w1 = m_we(1);
    if (w0) m_regs[0][enc] = v;
    if (w1) m_regs[1][enc] = v;
    if (instr != 0) m_retired++;
    if (regwrite && !m_legal()) begin
      m_sticky = 1;
      if (m_err < 255) m_err++;
    end
    #1;
    check_state(tag);
  endtask

  // driver: called just after a posedge; leaves time just after the next one
  task automatic step(input string tag, input logic rw, input logic [2:0] e,
                      input logic [3:0] h, input logic [31:0] a, input logic [31:0] m,
                      input logic [31:0] v, input logic [31:0] ins,
                      input logic [2:0] pa, input logic [2:0] pb);
    regwrite = rw; enc = e; hot = h; alu = a; mem = m; val2 = v;
    instr = ins; ra = pa; rb = pb;
    @(negedge clk);
    check_comb(tag);
    commit(tag);
  endtask

  task automatic idle();
    regwrite = 0; hot = 4'b0001; instr = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_clear();
    resetn = 1'b1;
    regwrite = 0; enc = 0; alu = 0; mem = 0; val2 = 0; hot = 4'b0001;
    instr = 0; ra = 0; rb = 0;
    #1 resetn = 1'b0;
    #1 check_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Directed: ALU write with same-cycle bypass and forwarding
    step("t1", 1, 3, 4'b0001, 32'hDEADBEEF, 0, 0, 32'h13, 3, 3);
    check("t1.r3", flat[0][127:96], 32'hDEADBEEF);

    // Select coverage into register 5
    step("t2b", 1, 5, 4'b0100, 0, 32'hA5123456, 0, 32'h13, 5, 1);
    check("t2b.r5", flat[0][191:160], 32'h000000A5);
    step("t2w", 1, 5, 4'b0010, 0, 32'hA5123456, 0, 32'h13, 5, 5);
    check("t2w.r5", flat[0][191:160], 32'hA5123456);
    step("t2v", 1, 5, 4'b1000, 0, 32'hA5123456, 32'h7, 32'h13, 2, 5);
    check("t2v.r5", flat[0][191:160], 32'h7);

    // Illegal select: no writes, counter and sticky
    for (int i = 0; i < 3; i++) step("t3", 1, 5, 4'b0011, 32'h55, 32'h66, 32'h77, 32'h13, 5, 3);
    check("t3.cnt", err_c[0], 8'd3);
    check("t3.stk", stk[1], 1'b1);
    step("t3off", 0, 5, 4'b0000, 0, 0, 0, 0, 5, 5);
    for (int i = 0; i < 300; i++) step("t3sat", 1, 3'($urandom_range(0, 7)), 4'b0000, 0, 0, 0, 0, 1, 2);
    check("t3.sat", err_c[0], 8'd255);

    // Register 0: ordinary in instance 0, hardwired zero in instance 1
    step("t4", 1, 0, 4'b0001, 32'h1234, 0, 0, 32'h13, 0, 0);
    check("t4.r0_ord", flat[0][31:0], 32'h1234);
    check("t4.r0_zero", flat[1][31:0], 32'h0);

    // Retire sequence: nonzero, bubble, nonzero, nonzero
    begin
      int unsigned base;
      base = m_retired;
      step("t5", 0, 1, 4'b0001, 0, 0, 0, 32'h1, 1, 1);
      step("t5", 0, 1, 4'b0001, 0, 0, 0, 32'h0, 1, 1);
      step("t5", 0, 1, 4'b0001, 0, 0, 0, 32'h8, 1, 1);
      step("t5", 0, 1, 4'b0001, 0, 0, 0, 32'hFFFFFFFF, 1, 1);
      check("t5.ret", ret_c[0], base + 3);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] h;
      logic [2:0] e;
      e = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) h = 4'(1 << $urandom_range(0, 3));
      else h = 4'($urandom_range(0, 15));
      step("rnd", 1'($urandom_range(0, 1)), e, h, $urandom, $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
           ($urandom_range(0, 1) == 1) ? e : 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-cycle while a write to register 2 is presented
    regwrite = 1; enc = 2; hot = 4'b0001; alu = 32'hAAAA5555; instr = 32'h13;
    ra = 1; rb = 3;
    #2 resetn = 1'b0;
    m_clear();
    #1 check_state("t6.async");
    check("t6.rda", rd_a[0], 32'h0);
    check("t6.rdb", rd_b[1], 32'h0);
    @(posedge clk); #1;
    check_state("t6.held");
    @(negedge clk);
    resetn = 1'b1;
    alu = 32'h0BADF00D;
    commit("t6.first");
    check("t6.r2", flat[0][95:64], 32'h0BADF00D);
    idle();
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
